exc_ctrl: RTL and testbench
===========================

// Module: exc_ctrl
// PURPOSE
//  Exception sequencer that drives the CP0 exception interface.
//  - Qualifies syscall/break/teq/eret decode flags and external IRQs against CP0 status.
//  - Drives the CP0 exception and eret pulses, the cause code and the EPC.
//  - Stalls the core and redirects the PC to the exception vector or back to EPC.
//  - Sits between the decode stage, the PC register and CP0.
// PARAMETERS
//  N_IRQ        4   number of external interrupt lines
//  SYNC_STAGES  2   flops in the IRQ synchronizer (>=2)
// PORTS
//  clk          in   1      core clock; CP0 samples on negedge
//  rst_n        in   1      asynchronous, active-low reset
//  instr_valid  in   1      decode-stage instruction valid this cycle
//  pc_in        in   32     PC of the decode-stage instruction
//  is_syscall   in   1      decoded syscall
//  is_break     in   1      decoded break
//  is_teq       in   1      decoded teq
//  teq_eq       in   1      rs==rt for teq
//  is_eret      in   1      decoded eret
//  mtc0_in      in   1      mtc0 in decode this cycle (CP0 gives mtc0 priority)
//  irq          in   N_IRQ  asynchronous interrupt requests, active-high
//  status       in   32     CP0 status register
//  exc_addr     in   32     CP0 exc_addr: EPC while eret=1, else the vector
//  exception    out  1      one-cycle pulse to CP0
//  eret         out  1      one-cycle pulse to CP0
//  cause        out  4      cause code to CP0; valid while exception=1
//  epc          out  32     PC to CP0; valid while exception=1
//  stall        out  1      hold the PC and decode stage
//  pc_load      out  1      force the PC to pc_target next edge
//  pc_target    out  32     redirect address
//  irq_pending  out  N_IRQ  latched, not-yet-taken interrupts
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; pending and synchronizer flops 0.
//  Reset asserted mid-sequence aborts immediately; no partial exception or eret pulse.
//  Qualification (only when instr_valid=1 and state IDLE):
//   - sys_ok = is_syscall & status[0] & status[1]
//   - brk_ok = is_break & status[0] & status[2]
//   - teq_ok = is_teq & teq_eq & status[0] & status[3]
//   - irq_ok = |(irq_pending & status[8+:N_IRQ]) & status[0]
//   - A masked syscall/break/teq retires as a NOP, with no stall.
//  Priority: eret > break > syscall > teq > irq.
//   - IRQ is served at lowest index first.
//  Cause codes: irq=4'h0, syscall=4'h8, break=4'h9, teq=4'hD.
//  FSM states:
//   - IDLE: on a qualified event with mtc0_in=0, latch cause and epc<=pc_in, assert stall.
//     - Go to TAKE, or to RET for eret.
//     - If mtc0_in=1 in the same cycle, assert stall for one cycle, stay in IDLE and
//       re-evaluate next cycle.
//   - TAKE: exception=1 and stall=1 for exactly one cycle.
//     - Clear the served irq_pending bit (irq case only).
//     - Next state VECTOR.
//   - VECTOR: pc_load=1, pc_target=exc_addr (the vector, since eret=0), stall=1.
//     - Next state IDLE.
//   - RET: eret=1, pc_load=1, pc_target=exc_addr (EPC), stall=1 for one cycle.
//     - Next state IDLE.
//  Latency: event in decode -> exception at +1 cycle -> PC redirect at +2.
//   - eret -> redirect at +1.
//  EPC: always pc_in of the trapping or interrupted instruction.
//   - For syscall/break/teq the handler advances EPC by 4 itself; for irq the
//     instruction re-executes.
//  IRQ path:
//   - irq[i] passes through SYNC_STAGES flops.
//   - A synchronized rising edge sets irq_pending[i].
//   - Pending bits survive masking and are cleared only when served.
//   - An edge coinciding with the clear of the same bit wins: the bit stays 1.
//  While in TAKE, VECTOR or RET, new decode events are ignored (held by stall).
//   - IRQ edges still latch into pending.
//  exception and eret are never high in the same cycle; pc_load is never high in IDLE.
// STRUCTURE
//  exc_pkg: cause-code localparams, FSM state encoding, status bit indices (IE=0,
//   SYS=1, BRK=2, TEQ=3, IM base=8).
//  Sub-module irq_sync (N_IRQ, SYNC_STAGES): synchronizer, edge detect, pending
//   set/clear. It takes a clr_mask input and produces the pending output.
// TESTING
//  1. status=32'h7, syscall at pc_in=32'h00400100 -> exception pulse at +1 with
//     cause=4'h8 and epc=32'h00400100; pc_load at +2 with pc_target=32'h00400004.
//  2. status=32'h1 (break masked), is_break=1 -> no exception, stall=0, no pc_load.
//  3. is_syscall and mtc0_in=1 together -> stall 1 cycle, no exception.
//     Next cycle with mtc0_in=0 -> exception with cause=4'h8.
//  4. status=32'h301, irq=4'b0011 raised -> irq_pending=4'b0011.
//     First take: cause=0, bit0 cleared. Next IDLE take serves bit1.
//  5. is_eret with exc_addr=32'h00400200 -> eret=1 and pc_load=1 in the same
//     cycle, pc_target=32'h00400200; back to IDLE after 1 cycle.
//  6. rst_n low during TAKE -> all outputs 0 asynchronously, state IDLE, pending cleared.

Source files
------------

// File: rtl/exc_pkg.sv
// Shared constants for the exception sequencer: CP0 status bit positions,
// cause codes and the FSM state encoding.
package exc_pkg;
    localparam int ST_IE  = 0;
    localparam int ST_SYS = 1;
    localparam int ST_BRK = 2;
    localparam int ST_TEQ = 3;
    localparam int ST_IM  = 8;

    localparam logic [3:0] CAUSE_IRQ = 4'h0;
    localparam logic [3:0] CAUSE_SYS = 4'h8;
    localparam logic [3:0] CAUSE_BRK = 4'h9;
    localparam logic [3:0] CAUSE_TEQ = 4'hD;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_TAKE   = 2'd1,
        S_VECTOR = 2'd2,
        S_RET    = 2'd3
    } state_t;
endpackage

// File: rtl/exc_ctrl_irq_sync.sv
// Per-line IRQ synchronizer with rising-edge detect and sticky pending bits.
// A new edge takes precedence over a same-cycle clear of that bit.
module irq_sync
    import exc_pkg::*;
#(
    parameter int N_IRQ       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IRQ-1:0] irq,
    input  logic [N_IRQ-1:0] clr_mask,
    output logic [N_IRQ-1:0] pending
);
    genvar gi;
    generate
        for (gi = 0; gi < N_IRQ; gi++) begin : g_line
            logic [SYNC_STAGES-1:0] sync_reg;
            logic                   prev_reg;
            logic                   pending_reg;
            logic                   rise;

            assign rise = sync_reg[SYNC_STAGES-1] & ~prev_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_reg    <= '0;
                    prev_reg    <= 1'b0;
                    pending_reg <= 1'b0;
                end else begin
                    sync_reg    <= {sync_reg[SYNC_STAGES-2:0], irq[gi]};
                    prev_reg    <= sync_reg[SYNC_STAGES-1];
                    pending_reg <= (pending_reg & ~clr_mask[gi]) | rise;
                end
            end

            assign pending[gi] = pending_reg;
        end
    endgenerate
endmodule

// File: rtl/exc_ctrl.sv
// Exception sequencer: qualifies decode traps and IRQs against CP0 status,
// pulses exception/eret to CP0 and redirects the PC.
module exc_ctrl
    import exc_pkg::*;
#(
    parameter int N_IRQ       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    input  logic [31:0]      pc_in,
    input  logic             is_syscall,
    input  logic             is_break,
    input  logic             is_teq,
    input  logic             teq_eq,
    input  logic             is_eret,
    input  logic             mtc0_in,
    input  logic [N_IRQ-1:0] irq,
    input  logic [31:0]      status,
    input  logic [31:0]      exc_addr,
    output logic             exception,
    output logic             eret,
    output logic [3:0]       cause,
    output logic [31:0]      epc,
    output logic             stall,
    output logic             pc_load,
    output logic [31:0]      pc_target,
    output logic [N_IRQ-1:0] irq_pending
);
    state_t           state_reg;
    logic             exception_reg, eret_reg, stall_reg, pc_load_reg;
    logic [3:0]       cause_reg;
    logic [31:0]      epc_reg;
    logic [N_IRQ-1:0] clr_sel_reg;
    logic [N_IRQ-1:0] clr_mask, masked, irq_onehot;
    logic             sys_ok, brk_ok, teq_ok, irq_ok, trap_ok, any_ok;
    logic             unused_status;

    assign unused_status = ^{status[31:ST_IM+N_IRQ], status[ST_IM-1:ST_TEQ+1]};

    irq_sync #(.N_IRQ(N_IRQ), .SYNC_STAGES(SYNC_STAGES)) u_irq_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .irq      (irq),
        .clr_mask (clr_mask),
        .pending  (irq_pending)
    );

    assign masked  = irq_pending & status[ST_IM +: N_IRQ];
    assign sys_ok  = is_syscall & status[ST_IE] & status[ST_SYS];
    assign brk_ok  = is_break & status[ST_IE] & status[ST_BRK];
    assign teq_ok  = is_teq & teq_eq & status[ST_IE] & status[ST_TEQ];
    assign irq_ok  = (|masked) & status[ST_IE];
    assign trap_ok = brk_ok | sys_ok | teq_ok;
    assign any_ok  = instr_valid & (is_eret | trap_ok | irq_ok);

    // Scan downwards so the lowest enabled pending line ends up selected.
    always_comb begin
        irq_onehot = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (masked[i]) begin
                irq_onehot    = '0;
                irq_onehot[i] = 1'b1;
            end
        end
    end

    assign clr_mask = (state_reg == S_TAKE) ? clr_sel_reg : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            exception_reg <= 1'b0;
            eret_reg      <= 1'b0;
            stall_reg     <= 1'b0;
            pc_load_reg   <= 1'b0;
            cause_reg     <= '0;
            epc_reg       <= '0;
            clr_sel_reg   <= '0;
        end else begin
            exception_reg <= 1'b0;
            eret_reg      <= 1'b0;
            stall_reg     <= 1'b0;
            pc_load_reg   <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (any_ok) begin
                        stall_reg <= 1'b1;
                        // CP0 serves an mtc0 first; hold one cycle and retry.
                        if (!mtc0_in) begin
                            if (is_eret) begin
                                state_reg   <= S_RET;
                                eret_reg    <= 1'b1;
                                pc_load_reg <= 1'b1;
                            end else begin
                                state_reg     <= S_TAKE;
                                exception_reg <= 1'b1;
                                epc_reg       <= pc_in;
                                clr_sel_reg   <= trap_ok ? '0 : irq_onehot;
                                if (brk_ok)      cause_reg <= CAUSE_BRK;
                                else if (sys_ok) cause_reg <= CAUSE_SYS;
                                else if (teq_ok) cause_reg <= CAUSE_TEQ;
                                else             cause_reg <= CAUSE_IRQ;
                            end
                        end
                    end
                end
                S_TAKE: begin
                    state_reg   <= S_VECTOR;
                    pc_load_reg <= 1'b1;
                    stall_reg   <= 1'b1;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign exception = exception_reg;
    assign eret      = eret_reg;
    assign stall     = stall_reg;
    assign pc_load   = pc_load_reg;
    assign cause     = cause_reg;
    assign epc       = epc_reg;
    // exc_addr is CP0's combinational EPC/vector mux, valid only while pc_load is up.
    assign pc_target = pc_load_reg ? exc_addr : '0;
endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: traps, masking, mtc0 conflict, IRQ service,
// eret and asynchronous reset.
module tb_exc_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid, is_syscall, is_break, is_teq, teq_eq, is_eret, mtc0_in;
    logic [31:0] pc_in, status, exc_addr;
    logic [3:0]  irq;
    logic        exception, eret, stall, pc_load;
    logic [3:0]  cause, irq_pending;
    logic [31:0] epc, pc_target;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    exc_ctrl #(.N_IRQ(4), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .pc_in       (pc_in),
        .is_syscall  (is_syscall),
        .is_break    (is_break),
        .is_teq      (is_teq),
        .teq_eq      (teq_eq),
        .is_eret     (is_eret),
        .mtc0_in     (mtc0_in),
        .irq         (irq),
        .status      (status),
        .exc_addr    (exc_addr),
        .exception   (exception),
        .eret        (eret),
        .cause       (cause),
        .epc         (epc),
        .stall       (stall),
        .pc_load     (pc_load),
        .pc_target   (pc_target),
        .irq_pending (irq_pending)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Flags packed as {exception, eret, stall, pc_load}.
    task automatic chk_flags(input string tag, input logic [3:0] exp);
        chk(tag, {28'h0, exception, eret, stall, pc_load}, {28'h0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_decode();
        instr_valid = 0; is_syscall = 0; is_break = 0; is_teq = 0;
        teq_eq = 0; is_eret = 0; mtc0_in = 0;
    endtask

    initial begin
        rst_n = 0; clear_decode(); pc_in = 0; status = 0; exc_addr = 0; irq = 0;
        #12;
        chk_flags("reset_flags", 4'b0000);
        chk("reset_cause", {28'h0, cause}, 32'h0);
        chk("reset_epc", epc, 32'h0);
        chk("reset_pc_target", pc_target, 32'h0);
        chk("reset_pending", {28'h0, irq_pending}, 32'h0);
        @(negedge clk); rst_n = 1;
        tick();

        // 1: enabled syscall
        status = 32'h7; exc_addr = 32'h00400004;
        instr_valid = 1; is_syscall = 1; pc_in = 32'h00400100;
        tick();
        $display("txn syscall take: exc=%b cause=%h epc=%h", exception, cause, epc);
        chk_flags("sys_take_flags", 4'b1010);
        chk("sys_cause", {28'h0, cause}, 32'h8);
        chk("sys_epc", epc, 32'h00400100);
        clear_decode();
        tick();
        $display("txn syscall vector: pc_load=%b target=%h", pc_load, pc_target);
        chk_flags("sys_vector_flags", 4'b0011);
        chk("sys_pc_target", pc_target, 32'h00400004);
        tick();
        chk_flags("sys_idle_flags", 4'b0000);

        // 2: masked break retires as NOP
        status = 32'h1; instr_valid = 1; is_break = 1; pc_in = 32'h00400108;
        tick();
        $display("txn masked break: exc=%b stall=%b", exception, stall);
        chk_flags("brk_masked_flags", 4'b0000);
        clear_decode();
        tick();
        chk_flags("brk_masked_after", 4'b0000);

        // 3: mtc0 conflict then retry
        status = 32'h7; instr_valid = 1; is_syscall = 1; mtc0_in = 1; pc_in = 32'h00400110;
        tick();
        $display("txn mtc0 conflict: exc=%b stall=%b", exception, stall);
        chk_flags("mtc0_hold_flags", 4'b0010);
        mtc0_in = 0;
        tick();
        $display("txn mtc0 retry: exc=%b cause=%h", exception, cause);
        chk_flags("mtc0_retry_flags", 4'b1010);
        chk("mtc0_retry_cause", {28'h0, cause}, 32'h8);
        chk("mtc0_retry_epc", epc, 32'h00400110);
        clear_decode();
        tick(); tick();

        // 4: two interrupts served lowest index first
        status = 32'h301; exc_addr = 32'h00400004; irq = 4'b0011;
        tick(); tick(); tick(); tick();
        $display("txn irq raise: pending=%b", irq_pending);
        chk("irq_pending_set", {28'h0, irq_pending}, 32'h3);
        instr_valid = 1; pc_in = 32'h00400120;
        tick();
        $display("txn irq take0: exc=%b cause=%h epc=%h", exception, cause, epc);
        chk_flags("irq0_take_flags", 4'b1010);
        chk("irq0_cause", {28'h0, cause}, 32'h0);
        chk("irq0_epc", epc, 32'h00400120);
        clear_decode();
        tick();
        chk("irq0_cleared", {28'h0, irq_pending}, 32'h2);
        chk("irq0_pc_target", pc_target, 32'h00400004);
        tick();
        instr_valid = 1; pc_in = 32'h00400124;
        tick();
        $display("txn irq take1: exc=%b cause=%h epc=%h", exception, cause, epc);
        chk_flags("irq1_take_flags", 4'b1010);
        chk("irq1_epc", epc, 32'h00400124);
        clear_decode();
        tick();
        chk("irq1_cleared", {28'h0, irq_pending}, 32'h0);
        tick();
        chk_flags("irq_idle_flags", 4'b0000);

        // 5: eret redirects to EPC
        exc_addr = 32'h00400200; instr_valid = 1; is_eret = 1;
        tick();
        $display("txn eret: eret=%b pc_load=%b target=%h", eret, pc_load, pc_target);
        chk_flags("eret_flags", 4'b0111);
        chk("eret_pc_target", pc_target, 32'h00400200);
        clear_decode();
        tick();
        chk_flags("eret_idle_flags", 4'b0000);

        // 6: asynchronous reset during TAKE, with a pending (masked) IRQ
        status = 32'h7; irq = 4'b0111;
        tick(); tick(); tick(); tick();
        chk("rst_pre_pending", {28'h0, irq_pending}, 32'h4);
        instr_valid = 1; is_syscall = 1; pc_in = 32'h00400130;
        tick();
        chk_flags("rst_pre_take", 4'b1010);
        clear_decode();
        #2 rst_n = 0;
        #1;
        $display("txn reset in take: exc=%b stall=%b pending=%b", exception, stall, irq_pending);
        chk_flags("rst_mid_flags", 4'b0000);
        chk("rst_mid_pending", {28'h0, irq_pending}, 32'h0);
        chk("rst_mid_epc", epc, 32'h0);
        @(negedge clk); rst_n = 1;
        tick();
        chk_flags("rst_after_flags", 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
